// File: rtl/instruction_fetch_controller.sv
// IF-stage fetch sequencer: owns the PC, issues instruction memory reads,
// waits MEM_LATENCY cycles and hands the word to IF/ID via valid/ready.
// Ports:
//   clk, rst (sync, active-low)
//   mem_addr/mem_req out, mem_data in        instruction memory side
//   branch_taken/branch_target in            EXE redirect
//   freeze/id_ready in                       hazard stall / IF-ID ready
//   if_valid/if_instr/if_pc_plus4 out        fetched instruction
module instruction_fetch_controller #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              freeze,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc_plus4
);

  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_req;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc4;

  state_t            w_state;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_req;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_valid;
  logic [DATA_W-1:0] w_instr;
  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_tgt;
  logic              w_consume;

  assign w_pc_inc  = r_pc + ADDR_W'(4);
  assign w_tgt     = branch_target & ~(ADDR_W'(3));
  assign w_consume = id_ready & ~freeze;

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_mem_addr = r_mem_addr;
    w_mem_req  = 1'b0;
    w_cnt      = r_cnt;
    w_valid    = r_valid;
    w_instr    = r_instr;
    w_pc4      = r_pc4;
    // A redirect overrides every state and flushes any held or
    // in-flight instruction.
    if (branch_taken) begin
      w_pc       = w_tgt;
      w_mem_addr = w_tgt;
      w_mem_req  = 1'b1;
      w_cnt      = LAT;
      w_valid    = 1'b0;
      w_instr    = '0;
      w_state    = S_WAIT;
    end else begin
      unique case (r_state)
        S_ISSUE: begin
          w_mem_addr = r_pc;
          w_mem_req  = 1'b1;
          w_cnt      = LAT;
          w_state    = S_WAIT;
        end
        S_WAIT: begin
          // Freeze does not pause the memory wait; the word parks in HOLD.
          w_cnt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_instr = mem_data;
            w_pc4   = w_pc_inc;
            w_valid = 1'b1;
            w_state = S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_consume) begin
            w_pc       = w_pc_inc;
            w_mem_addr = w_pc_inc;
            w_mem_req  = 1'b1;
            w_cnt      = LAT;
            w_valid    = 1'b0;
            w_instr    = '0;
            w_state    = S_WAIT;
          end
        end
        default: w_state = S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_ISSUE;
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc4      <= '0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_mem_addr <= w_mem_addr;
      r_mem_req  <= w_mem_req;
      r_cnt      <= w_cnt;
      r_valid    <= w_valid;
      r_instr    <= w_instr;
      r_pc4      <= w_pc4;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_req     = r_mem_req;
  assign if_valid    = r_valid;
  assign if_instr    = r_instr;
  assign if_pc_plus4 = r_pc4;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller: two instances
// (latency 2 / PC 0, latency 3 / PC 0xFFFFFFFC) with latency-gated memories.
module tb_instruction_fetch_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h0) ? 32'h8001060A : (a ^ 32'h5A5A0000);
  endfunction

  // instance A: MEM_LATENCY=2, RESET_PC=0
  logic        a_rst = 1'b0, a_bt = 1'b0, a_frz = 1'b0, a_rdy = 1'b0;
  logic [31:0] a_tgt = '0;
  logic [31:0] a_addr, a_data, a_instr, a_pc4;
  logic        a_req, a_valid;

  instruction_fetch_controller #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .RESET_PC(32'h0)
  ) u_a (
    .clk(clk), .rst(a_rst), .mem_addr(a_addr), .mem_req(a_req),
    .mem_data(a_data), .branch_taken(a_bt), .branch_target(a_tgt),
    .freeze(a_frz), .id_ready(a_rdy), .if_valid(a_valid),
    .if_instr(a_instr), .if_pc_plus4(a_pc4)
  );

  // instance B: MEM_LATENCY=3, RESET_PC=0xFFFFFFFC
  logic        b_rst = 1'b0, b_rdy = 1'b0;
  logic [31:0] b_addr, b_data, b_instr, b_pc4;
  logic        b_req, b_valid;

  instruction_fetch_controller #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .RESET_PC(32'hFFFFFFFC)
  ) u_b (
    .clk(clk), .rst(b_rst), .mem_addr(b_addr), .mem_req(b_req),
    .mem_data(b_data), .branch_taken(1'b0), .branch_target(32'h0),
    .freeze(1'b0), .id_ready(b_rdy), .if_valid(b_valid),
    .if_instr(b_instr), .if_pc_plus4(b_pc4)
  );

  // Memories: data is only correct on the edge exactly LATENCY edges
  // after the issue edge; any other sample sees a poison word.
  int          lat_a = 0, lat_b = 0;
  logic [31:0] ma_a = '0, ma_b = '0;
  always @(negedge clk) begin
    if (a_req) begin
      lat_a = 2;
      ma_a  = a_addr;
    end else if (lat_a > 0) lat_a = lat_a - 1;
    if (b_req) begin
      lat_b = 3;
      ma_b  = b_addr;
    end else if (lat_b > 0) lat_b = lat_b - 1;
  end
  assign a_data = (lat_a == 1) ? rom(ma_a) : 32'hBAD0BAD0;
  assign b_data = (lat_b == 1) ? rom(ma_b) : 32'hBAD0BAD0;

  typedef struct packed {
    logic        rst;
    logic        bt;
    logic [31:0] tgt;
    logic        frz;
    logic        rdy;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic bt, input logic [31:0] t,
                     input logic f, input logic rd, input logic [31:0] ea,
                     input logic eq, input logic ev, input logic [31:0] ei,
                     input logic [31:0] ep);
    vec_t v;
    v = '{r, bt, t, f, rd, ea, eq, ev, ei, ep};
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check5(input string p, input int idx,
                        input logic [31:0] ad, input logic rq,
                        input logic vl, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic [31:0] e_ad,
                        input logic e_rq, input logic e_vl,
                        input logic [31:0] e_ins, input logic [31:0] e_pc4);
    check({p, ".mem_addr"}, idx, ad, e_ad);
    check({p, ".mem_req"}, idx, {31'b0, rq}, {31'b0, e_rq});
    check({p, ".if_valid"}, idx, {31'b0, vl}, {31'b0, e_vl});
    check({p, ".if_instr"}, idx, ins, e_ins);
    check({p, ".if_pc_plus4"}, idx, pc4, e_pc4);
  endtask

  task automatic step_b(input int idx, input logic r, input logic rd,
                        input logic [31:0] ea, input logic eq,
                        input logic ev, input logic [31:0] ei,
                        input logic [31:0] ep);
    b_rst = r;
    b_rdy = rd;
    @(posedge clk);
    #1;
    check5("B", idx, b_addr, b_req, b_valid, b_instr, b_pc4,
           ea, eq, ev, ei, ep);
  endtask

  initial begin
    // reset, then straight-line fetch 0,4,8
    add(0,0,0,0,1, 32'h0,  0,0, 32'h0,        32'h0);
    add(0,0,0,0,1, 32'h0,  0,0, 32'h0,        32'h0);
    add(1,0,0,0,1, 32'h0,  1,0, 32'h0,        32'h0);
    add(1,0,0,0,1, 32'h0,  0,0, 32'h0,        32'h0);
    add(1,0,0,0,1, 32'h0,  0,1, 32'h8001060A, 32'h4);
    add(1,0,0,0,1, 32'h4,  1,0, 32'h0,        32'h4);
    add(1,0,0,0,1, 32'h4,  0,0, 32'h0,        32'h4);
    add(1,0,0,0,1, 32'h4,  0,1, 32'h5A5A0004, 32'h8);
    add(1,0,0,0,1, 32'h8,  1,0, 32'h0,        32'h8);
    add(1,0,0,0,1, 32'h8,  0,0, 32'h0,        32'h8);
    add(1,0,0,0,1, 32'h8,  0,1, 32'h5A5A0008, 32'hC);
    // freeze 5 cycles in HOLD at pc=8
    for (int i = 0; i < 5; i++)
      add(1,0,0,1,1, 32'h8, 0,1, 32'h5A5A0008, 32'hC);
    add(1,0,0,0,1, 32'hC,  1,0, 32'h0,        32'hC);
    add(1,0,0,0,1, 32'hC,  0,0, 32'h0,        32'hC);
    add(1,0,0,0,1, 32'hC,  0,1, 32'h5A5A000C, 32'h10);
    add(1,0,0,0,1, 32'h10, 1,0, 32'h0,        32'h10);
    // redirect during WAIT of pc=0x10
    add(1,1,32'hB2,0,1, 32'hB0, 1,0, 32'h0, 32'h10);
    add(1,0,0,0,1, 32'hB0, 0,0, 32'h0,        32'h10);
    add(1,0,0,0,1, 32'hB0, 0,1, 32'h5A5A00B0, 32'hB4);
    // redirect + consume in HOLD
    add(1,1,32'h40,0,1, 32'h40, 1,0, 32'h0, 32'hB4);
    add(1,0,0,0,1, 32'h40, 0,0, 32'h0,        32'hB4);
    add(1,0,0,0,1, 32'h40, 0,1, 32'h5A5A0040, 32'h44);
    // redirect + freeze in HOLD; freeze does not pause WAIT
    add(1,1,32'h103,1,1, 32'h100, 1,0, 32'h0, 32'h44);
    add(1,0,0,1,1, 32'h100, 0,0, 32'h0,        32'h44);
    add(1,0,0,1,1, 32'h100, 0,1, 32'h5A5A0100, 32'h104);
    add(1,0,0,0,0, 32'h100, 0,1, 32'h5A5A0100, 32'h104);
    add(1,0,0,0,1, 32'h104, 1,0, 32'h0,        32'h104);
    add(1,0,0,0,1, 32'h104, 0,0, 32'h0,        32'h104);
    // redirect on the capture edge drops mem_data
    add(1,1,32'h20,0,1, 32'h20, 1,0, 32'h0, 32'h104);
    add(1,0,0,0,1, 32'h20, 0,0, 32'h0,        32'h104);
    add(1,0,0,0,1, 32'h20, 0,1, 32'h5A5A0020, 32'h24);

    foreach (vq[i]) begin
      a_rst = vq[i].rst;
      a_bt  = vq[i].bt;
      a_tgt = vq[i].tgt;
      a_frz = vq[i].frz;
      a_rdy = vq[i].rdy;
      @(posedge clk);
      #1;
      check5("A", i, a_addr, a_req, a_valid, a_instr, a_pc4,
             vq[i].e_addr, vq[i].e_req, vq[i].e_v,
             vq[i].e_instr, vq[i].e_pc4);
    end
    a_bt = 1'b0;

    // B: wrap-around from 0xFFFFFFFC, then reset mid-WAIT
    check5("B", 0, b_addr, b_req, b_valid, b_instr, b_pc4,
           32'hFFFFFFFC, 0, 0, 32'h0, 32'h0);
    step_b(1,  1,1, 32'hFFFFFFFC, 1,0, 32'h0,        32'h0);
    step_b(2,  1,1, 32'hFFFFFFFC, 0,0, 32'h0,        32'h0);
    step_b(3,  1,1, 32'hFFFFFFFC, 0,0, 32'h0,        32'h0);
    step_b(4,  1,1, 32'hFFFFFFFC, 0,1, 32'hA5A5FFFC, 32'h0);
    step_b(5,  1,1, 32'h0,        1,0, 32'h0,        32'h0);
    step_b(6,  1,1, 32'h0,        0,0, 32'h0,        32'h0);
    step_b(7,  1,1, 32'h0,        0,0, 32'h0,        32'h0);
    step_b(8,  1,1, 32'h0,        0,1, 32'h8001060A, 32'h4);
    step_b(9,  1,1, 32'h4,        1,0, 32'h0,        32'h4);
    step_b(10, 1,1, 32'h4,        0,0, 32'h0,        32'h4);
    step_b(11, 0,1, 32'hFFFFFFFC, 0,0, 32'h0,        32'h0);
    step_b(12, 1,1, 32'hFFFFFFFC, 1,0, 32'h0,        32'h0);
    step_b(13, 1,1, 32'hFFFFFFFC, 0,0, 32'h0,        32'h0);
    step_b(14, 1,1, 32'hFFFFFFFC, 0,0, 32'h0,        32'h0);
    step_b(15, 1,1, 32'hFFFFFFFC, 0,1, 32'hA5A5FFFC, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
